// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester arbiter in front of a single-port synchronous SRAM.
// Round-robin on contention, one grant per cycle, registered command stage and
// a two-deep read tracker that routes returning read data to its requester.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rst
);

  // Priority pointer: 0 favours requester 0, 1 favours requester 1.
  logic       ptr;
  // Read tracker stages: valid flag and requester id, stage 2 drives rvalid.
  logic [1:0] rd_v;
  logic [1:0] rd_id;
  logic       any_gnt;
  logic       gnt_we;

  // Grant decode: lone requester wins, contention resolved by the pointer.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (rst_n) begin
      gnt0 = req0 & (~req1 | ~ptr);
      gnt1 = req1 & (~req0 |  ptr);
    end
    any_gnt = gnt0 | gnt1;
    gnt_we  = gnt1 ? we1 : we0;
  end

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clk) begin
    if (!rst_n)    ptr <= 1'b0;
    else if (gnt0) ptr <= 1'b1;
    else if (gnt1) ptr <= 1'b0;
  end

  // Command stage: register the granted access towards the SRAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (any_gnt) begin
      mem_wr_en <= gnt_we;
      mem_rd_en <= ~gnt_we;
      mem_addr  <= gnt1 ? addr1  : addr0;
      mem_wdata <= gnt1 ? wdata1 : wdata0;
    end else begin
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end
  end

  // Read tracker: {read, id} shifted two cycles to meet SRAM read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v  <= '0;
      rd_id <= '0;
    end else begin
      rd_v  <= {rd_v[0], any_gnt & ~gnt_we};
      rd_id <= {rd_id[0], gnt1};
    end
  end

  assign rvalid0 = rd_v[1] & ~rd_id[1];
  assign rvalid1 = rd_v[1] &  rd_id[1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
  assign mem_rst = ~rst_n;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- reqN (N=0,1)  input  1  access request.
- weN  input  1  1=write, 0=read.
- addrN  input  ADDR_W  address.
- wdataN  input  DATA_W  write data.
- gntN  output  1  request accepted this cycle.
- rvalidN  output  1  read data valid.
- rdataN  output  DATA_W  read data.
- mem_wr_en  output  1  SRAM write enable.
- mem_rd_en  output  1  SRAM read enable.
- mem_addr  output  ADDR_W  SRAM address.
- mem_wdata  output  DATA_W  SRAM write data.
- mem_rdata  input  DATA_W  SRAM read data.
- mem_rst  output  1  active-high SRAM reset.

Function
REQ-005 Arbitrate the single-port SRAM between requesters 0 and 1, with at most one grant per cycle.
REQ-006 gntN SHALL be combinational from reqN and the priority pointer, and forced 0 while rst_n=0.
REQ-007 Grant rules:
- Only one requester active: grant it.
- Both active: grant the one the pointer selects.
- Neither active: no grant.
REQ-008 Pointer SHALL be 1 bit, register-based, and after a grant to N SHALL point to the other requester.
- Unchanged on cycles with no grant.
REQ-009 Requester SHALL hold reqN, weN, addrN and wdataN stable until gntN=1; the transfer occurs in the cycle with reqN&gntN.
REQ-010 Command stage, registered:
- Edge after grant: mem_addr <= granted addr; mem_wdata <= granted wdata; mem_wr_en <= we; mem_rd_en <= ~we.
- No grant: mem_wr_en and mem_rd_en SHALL be 0; mem_addr and mem_wdata hold.
REQ-011 SRAM model: captures on the edge that ends the mem_*_en cycle; mem_rdata is valid the following cycle.
REQ-012 Read latency: a read granted in cycle T SHALL give rvalidN=1 for exactly one cycle, at T+2, with rdataN = mem_rdata.
REQ-013 rdataN SHALL be driven from mem_rdata at all times; it is meaningful only when rvalidN=1.
REQ-014 A 2-stage shift register SHALL carry {read, requester id} to produce rvalid0/rvalid1; they are never both 1.
REQ-015 Grants SHALL be fully pipelined: back-to-back grants every cycle, with reads and writes mixed freely.
REQ-016 Write then read to the same address, granted in consecutive cycles: the read SHALL return the new data.
REQ-017 Writes SHALL produce no rvalid.
REQ-018 mem_rst SHALL equal ~rst_n combinationally.

Reset
REQ-019 While rst_n=0 at a rising edge, the following SHALL be set:
- mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wdata=0.
- rvalid0=0, rvalid1=0.
- pointer selects requester 0.
REQ-020 Reads in flight when reset asserts SHALL be dropped, with no rvalid after reset.
REQ-021 The first grant SHALL be possible in the first cycle with rst_n=1.

Verification
REQ-022 req0 write addr=3 wdata=0xA5, then req0 read addr=3 -> rvalid0=1 two cycles after the read grant, rdata0=0xA5.
REQ-023 req0 and req1 both held high for 4 cycles after reset -> grants alternate 0,1,0,1; mem_addr follows one cycle later.
REQ-024 req1 writes addr=7 wdata=0x3C in cycle T, req0 reads addr=7 in T+1 -> rvalid0 at T+3 with 0x3C, rvalid1 stays 0.
REQ-025 Back-to-back reads: req1 reads addr=0..3 over 4 consecutive cycles -> rvalid1 high 4 consecutive cycles, data in order.
REQ-026 rst_n low one cycle after a read grant -> no rvalid; mem_*_en=0, pointer=0, mem_rst=1 during reset.
